// File: rtl/pc_callstack.sv
// ============================================================================
// Module   : pc_callstack
// Purpose  : Program counter with a bounded LIFO return-address stack and
//            sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_callstack #(
    parameter int             AW        = 8,
    parameter int             DEPTH     = 8,
    parameter logic [AW-1:0]  RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inc,
    input  logic                       jmp,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       stall,
    input  logic                       clr_err,
    input  logic [AW-1:0]              addr_in,
    output logic [AW-1:0]              pc_o,
    output logic [$clog2(DEPTH+1)-1:0] sp_o,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [SPW-1:0] c_sp_one  = SPW'(1);
    localparam logic [SPW-1:0] c_sp_full = SPW'(DEPTH);
    localparam logic [AW-1:0]  c_pc_one  = AW'(1);

    logic [AW-1:0]  r_pc;
    logic [SPW-1:0] r_sp;
    logic           r_ovf;
    logic           r_unf;
    logic [AW-1:0]  r_stack [DEPTH];

    logic [AW-1:0]  w_pc_next;
    logic [SPW-1:0] w_sp_next;
    logic           w_ovf_next;
    logic           w_unf_next;
    logic           w_push;
    logic           w_full;
    logic           w_empty;
    logic [SPW-1:0] w_sp_dec;
    logic [AW-1:0]  w_ret_addr;
    logic [IW-1:0]  w_push_idx;
    logic [IW-1:0]  w_top_idx;

    assign w_full     = (r_sp == c_sp_full);
    assign w_empty    = (r_sp == '0);
    assign w_sp_dec   = r_sp - c_sp_one;
    assign w_ret_addr = r_pc + c_pc_one;
    assign w_push_idx = r_sp[IW-1:0];
    assign w_top_idx  = w_sp_dec[IW-1:0];

    // Priority: stall > ret > call > jmp > inc. Error setting is evaluated
    // after clr_err so a same-cycle error leaves its flag set.
    always_comb begin
        w_pc_next  = r_pc;
        w_sp_next  = r_sp;
        w_ovf_next = r_ovf;
        w_unf_next = r_unf;
        w_push     = 1'b0;
        if (!stall) begin
            if (clr_err) begin
                w_ovf_next = 1'b0;
                w_unf_next = 1'b0;
            end
            if (ret) begin
                if (w_empty) begin
                    w_unf_next = 1'b1;
                end else begin
                    w_pc_next = r_stack[w_top_idx];
                    w_sp_next = w_sp_dec;
                end
            end else if (call) begin
                if (w_full) begin
                    w_ovf_next = 1'b1;
                end else begin
                    w_push    = 1'b1;
                    w_pc_next = addr_in;
                    w_sp_next = r_sp + c_sp_one;
                end
            end else if (jmp) begin
                w_pc_next = addr_in;
            end else if (inc) begin
                w_pc_next = r_pc + c_pc_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc  <= RESET_VEC;
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_next;
            r_sp  <= w_sp_next;
            r_ovf <= w_ovf_next;
            r_unf <= w_unf_next;
        end
    end

    // Storage is not reset; entries at or above sp are never read.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_stack[w_push_idx] <= w_ret_addr;
        end
    end

    assign pc_o  = r_pc;
    assign sp_o  = r_sp;
    assign full  = w_full;
    assign empty = w_empty;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_pc_callstack.sv
// ============================================================================
// Module   : tb_pc_callstack
// Purpose  : Directed self-checking bench for pc_callstack (AW=8, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_callstack;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inc = 1'b0;
    logic          jmp = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic          stall = 1'b0;
    logic          clr_err = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [AW-1:0] pc_o;
    logic [2:0]    sp_o;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;

    int checks   = 0;
    int failures = 0;

    pc_callstack #(.AW(AW), .DEPTH(DEPTH), .RESET_VEC(8'h00)) dut (
        .clk(clk), .rst(rst), .inc(inc), .jmp(jmp), .call(call), .ret(ret),
        .stall(stall), .clr_err(clr_err), .addr_in(addr_in),
        .pc_o(pc_o), .sp_o(sp_o), .full(full), .empty(empty),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PC as a number, the stack as a queue of return addresses.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk[$];
    logic          m_ovf;
    logic          m_unf;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc  = 8'h00;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!stall) begin
            if (clr_err) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (ret) begin
                if (m_stk.size() == 0) m_unf = 1'b1;
                else m_pc = m_stk.pop_back();
            end else if (call) begin
                if (m_stk.size() == DEPTH) m_ovf = 1'b1;
                else begin
                    m_stk.push_back(m_pc + 8'd1);
                    m_pc = addr_in;
                end
            end else if (jmp) begin
                m_pc = addr_in;
            end else if (inc) begin
                m_pc = m_pc + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_pc", int'(pc_o), int'(m_pc));
        chk("model_sp", int'(sp_o), m_stk.size());
        chk("model_full", int'(full), int'(m_stk.size() == DEPTH));
        chk("model_empty", int'(empty), int'(m_stk.size() == 0));
        chk("model_ovf", int'(ovf), int'(m_ovf));
        chk("model_unf", int'(unf), int'(m_unf));
    end

    // Drive one cycle of commands at the falling edge, return after the next falling edge.
    task automatic step(input logic s, input logic r, input logic c, input logic j,
                        input logic i, input logic ce, input logic [AW-1:0] a);
        stall = s; ret = r; call = c; jmp = j; inc = i; clr_err = ce; addr_in = a;
        @(posedge clk);
        @(negedge clk);
        stall = 0; ret = 0; call = 0; jmp = 0; inc = 0; clr_err = 0;
    endtask

    task automatic do_inc();                 step(0, 0, 0, 0, 1, 0, 8'h00); endtask
    task automatic do_jmp(input logic [7:0] a);  step(0, 0, 0, 1, 0, 0, a); endtask
    task automatic do_call(input logic [7:0] a); step(0, 0, 1, 0, 0, 0, a); endtask
    task automatic do_ret();                 step(0, 1, 0, 0, 0, 0, 8'h00); endtask

    initial begin
        // Reset held for two cycles
        repeat (2) @(negedge clk);
        chk("rst_pc", int'(pc_o), 0);
        chk("rst_sp", int'(sp_o), 0);
        chk("rst_empty", int'(empty), 1);
        rst = 1'b1;

        // Counting up from reset
        do_inc(); chk("inc1", int'(pc_o), 8'h01);
        do_inc(); chk("inc2", int'(pc_o), 8'h02);
        do_inc(); chk("inc3", int'(pc_o), 8'h03);
        chk("inc_sp", int'(sp_o), 0);

        // Single call/return
        do_jmp(8'h10);  chk("jmp", int'(pc_o), 8'h10);
        do_call(8'h40); chk("call_pc", int'(pc_o), 8'h40); chk("call_sp", int'(sp_o), 1);
        do_ret();       chk("ret_pc", int'(pc_o), 8'h11); chk("ret_sp", int'(sp_o), 0);

        // Nested calls unwind in reverse order
        do_jmp(8'h05);
        do_call(8'h20); do_inc();
        do_call(8'h30); do_inc();
        do_call(8'h40); chk("nest_sp", int'(sp_o), 3);
        do_ret(); chk("nest_ret1", int'(pc_o), 8'h32);
        do_ret(); chk("nest_ret2", int'(pc_o), 8'h22);
        do_ret(); chk("nest_ret3", int'(pc_o), 8'h06);
        chk("nest_sp0", int'(sp_o), 0);

        // Fill the stack, then overflow
        do_call(8'h50); do_call(8'h60); do_call(8'h70); do_call(8'h80);
        chk("full_flag", int'(full), 1);
        do_call(8'h99);
        chk("ovf_pc", int'(pc_o), 8'h80); chk("ovf_sp", int'(sp_o), 4); chk("ovf_set", int'(ovf), 1);
        step(0, 0, 0, 0, 0, 1, 8'h00); chk("ovf_clr", int'(ovf), 0);
        step(0, 0, 1, 0, 0, 1, 8'h99); chk("ovf_vs_clr", int'(ovf), 1);
        step(0, 0, 0, 0, 0, 1, 8'h00);

        // ret beats call/jmp/inc
        step(0, 1, 1, 1, 1, 0, 8'hAA); chk("prio_pc", int'(pc_o), 8'h71); chk("prio_sp", int'(sp_o), 3);
        // call beats jmp/inc
        step(0, 0, 1, 1, 1, 0, 8'hB0); chk("prio_call", int'(pc_o), 8'hB0);
        do_ret(); do_ret(); do_ret(); do_ret();
        chk("drain_pc", int'(pc_o), 8'h07); chk("drain_sp", int'(sp_o), 0);

        // Underflow after reset
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        do_ret(); chk("unf_pc", int'(pc_o), 8'h00); chk("unf_set", int'(unf), 1);
        step(0, 1, 0, 0, 0, 1, 8'h00); chk("unf_vs_clr", int'(unf), 1);
        step(0, 0, 0, 0, 0, 1, 8'h00); chk("unf_clr", int'(unf), 0);

        // Address wrap
        do_jmp(8'hFF); do_inc(); chk("wrap_inc", int'(pc_o), 8'h00);
        do_jmp(8'hFF); do_call(8'h10); chk("wrap_call", int'(pc_o), 8'h10);
        do_ret(); chk("wrap_ret", int'(pc_o), 8'h00);

        // Stall freezes everything, including clr_err
        do_call(8'h10); do_ret(); do_ret(); chk("stall_pre_unf", int'(unf), 1);
        do_call(8'h10);
        step(1, 0, 1, 0, 0, 1, 8'h20);
        chk("stall_pc", int'(pc_o), 8'h10); chk("stall_sp", int'(sp_o), 1); chk("stall_unf", int'(unf), 1);

        // Asynchronous reset in the middle of a call
        call = 1'b1; addr_in = 8'h33;
        #2 rst = 1'b0;
        #1;
        chk("async_pc", int'(pc_o), 8'h00); chk("async_sp", int'(sp_o), 0);
        chk("async_unf", int'(unf), 0); chk("async_empty", int'(empty), 1);
        @(negedge clk);
        chk("rst_hold_pc", int'(pc_o), 8'h00);
        call = 1'b0; rst = 1'b1;
        do_inc(); chk("post_rst_inc", int'(pc_o), 8'h01); chk("post_rst_sp", int'(sp_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_callstack.md
PC_CALLSTACK -- requirements
Module: pc_callstack

Interface
REQ-001 Parameter AW, default 8, meaning program-address width in bits, legal range 4..16.
REQ-002 Parameter DEPTH, default 8, meaning return-stack entries, legal range 2..64.
REQ-003 Parameter RESET_VEC, default 0, meaning PC value loaded at reset, AW bits wide.
REQ-004 Port clk, input, 1, meaning single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, meaning reset, asynchronous assert and active-low (0 = reset).
REQ-006 Port inc, input, 1, meaning advance the PC by one.
REQ-007 Port jmp, input, 1, meaning load the PC from addr_in.
REQ-008 Port call, input, 1, meaning push the return address and load the PC from addr_in.
REQ-009 Port ret, input, 1, meaning pop the top of stack into the PC.
REQ-010 Port stall, input, 1, meaning freeze all state this cycle.
REQ-011 Port clr_err, input, 1, meaning clear the sticky error flags.
REQ-012 Port addr_in, input, AW, meaning jump or call target.
REQ-013 Port pc_o, output, AW, meaning current PC (registered).
REQ-014 Port sp_o, output, clog2(DEPTH+1), meaning number of valid stack entries.
REQ-015 Port full, output, 1, meaning sp_o == DEPTH (combinational from sp).
REQ-016 Port empty, output, 1, meaning sp_o == 0 (combinational from sp).
REQ-017 Port ovf, output, 1, meaning sticky flag for a call issued while full.
REQ-018 Port unf, output, 1, meaning sticky flag for a ret issued while empty.

Function
REQ-019 Commands are sampled at the clk rising edge; pc_o and sp_o reflect the command after that edge (1-cycle latency, no combinational path from command inputs to pc_o).
REQ-020 Command priority when several are high: stall > ret > call > jmp > inc; only the winning command takes effect.
REQ-021 stall=1: pc_o, stack contents, sp_o, ovf and unf all hold; clr_err is also ignored.
REQ-022 No command asserted: pc_o and the stack hold.
REQ-023 inc: pc_o <= pc_o + 1 mod 2^AW; (2^AW)-1 wraps to 0 with no flag.
REQ-024 jmp: pc_o <= addr_in; the stack is unchanged.
REQ-025 call, not full: stack[sp] <= pc_o + 1 mod 2^AW; sp <= sp + 1; pc_o <= addr_in.
REQ-026 call while full: the push is suppressed, pc_o and sp hold, and ovf <= 1.
REQ-027 ret, not empty: pc_o <= stack[sp-1]; sp <= sp - 1.
REQ-028 ret while empty: pc_o and sp hold, and unf <= 1.
REQ-029 ovf and unf remain set until clr_err=1 (non-stalled) or reset; clr_err clears both on the next edge.
REQ-030 A same-cycle error event has priority over clr_err: if an error occurs in the same cycle as clr_err, the flag ends set.
REQ-031 The stack is LIFO; entries at index >= sp are don't-care and are never observable on pc_o.
REQ-032 sp never exceeds DEPTH and never goes below 0 under any input sequence.

Reset
REQ-033 While rst=0: pc_o = RESET_VEC, sp_o = 0, empty = 1, full = 0, ovf = 0, unf = 0, asynchronously.
REQ-034 Stack storage content is not reset; it is logically invalidated because sp = 0.
REQ-035 Reset asserted mid-operation (for example, in the same cycle as a call) overrides the command; no push is retained.
REQ-036 After rst deasserts, the first command takes effect at the first rising edge at which rst=1.

Verification
REQ-037 AW=8, DEPTH=4, reset then inc x3 -> pc_o = 0,1,2,3 on successive edges, sp_o = 0.
REQ-038 pc_o = 0x10, call with addr_in = 0x40 -> pc_o = 0x40, sp_o = 1; then ret -> pc_o = 0x11, sp_o = 0.
REQ-039 Nested calls 0x20, 0x30, 0x40 from pc 0x05 with incs between, then ret x3 -> return addresses are popped in reverse order and sp_o ends at 0.
REQ-040 4 calls (full = 1), then a 5th call to 0x99 -> pc_o unchanged, sp_o = 4, ovf = 1; clr_err -> ovf = 0.
REQ-041 Reset, then ret -> pc_o = RESET_VEC, unf = 1; ret with clr_err in the same cycle -> unf stays 1.
REQ-042 pc_o = 0xFF, inc -> 0x00; pc_o = 0xFF, call 0x10 -> the stacked return address is 0x00; stall with call asserted -> no change; rst=0 mid-sequence -> all outputs return to their reset values immediately.
